// File: rtl/v4l2_ctrl_name_dispatch.sv
// ----------------------------------------------------------------------------
// v4l2_ctrl_name_dispatch
//
// Request/response wrapper in front of the v4l2_ctrl_get_name call interface.
// It accepts one control ID at a time and drives the call's start/id/stall
// inputs. Each returned 64-bit name pointer is queued in a small result FIFO,
// tagged with the ID that produced it.
//
// A request is accepted only when the FSM is idle and the FIFO has a free
// slot. Because only one call is ever in flight, that check reserves the
// slot, so a result never has to wait for FIFO space.
//
// Optional feature (macro V4L2_NAME_NULL_FILTER_EN):
//   When defined, a result with a null name pointer is not queued. Instead a
//   saturating 16-bit drop counter is incremented.
//   When undefined, every result is queued and drop_count is tied to 0.
//
// Parameters:
//   FIFO_DEPTH       result FIFO entries (power of two, >= 2)
// Ports:
//   clock            sole clock
//   resetn           asynchronous active-low reset (shared with get_name)
//   req_valid/ready  ID request handshake; req_id is the control ID
//   call_start       get_name start
//   call_busy        get_name busy
//   call_id          get_name id (held stable while the call is issued)
//   call_done        get_name done
//   call_returndata  get_name returndata (name pointer)
//   call_stall       get_name stall (low only while waiting for done)
//   rsp_valid/ready  result handshake; rsp_id/rsp_name give the FIFO head
//   drop_count       saturating count of filtered null results
// ----------------------------------------------------------------------------
module v4l2_ctrl_name_dispatch #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_id,
   output logic        call_start,
   input  logic        call_busy,
   output logic [31:0] call_id,
   input  logic        call_done,
   input  logic [63:0] call_returndata,
   output logic        call_stall,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_id,
   output logic [63:0] rsp_name,
   output logic [15:0] drop_count
);

   // state | meaning
   // ------+-------------------------------------------------------------
   // IDLE  | no call in flight; accept a request if a FIFO slot is free
   // ISSUE | call_start high with call_id; wait for get_name to take it
   // WAIT  | call accepted; stall released; wait for call_done

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          ready_en;
   logic          slot_free;
   logic          accept;
   logic          done_in_wait;
   logic          null_result;
   logic          push;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [95:0]   mem [FIFO_DEPTH];

   // ready_en keeps req_ready low while reset is asserted and opens it on the
   // first clock after release.
   assign slot_free    = ready_en && (fifo_count < DEPTH_C);
   assign accept       = req_valid && req_ready;
   assign done_in_wait = (state == ST_WAIT) && call_done;

`ifdef V4L2_NAME_NULL_FILTER_EN
   assign null_result = (call_returndata == 64'd0);
`else
   assign null_result = 1'b0;
`endif

   assign push = done_in_wait && !null_result;
   assign pop  = rsp_valid && rsp_ready;

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      call_start = 1'b0;
      call_stall = 1'b1;
      case (state)
         ST_IDLE: begin
            req_ready = slot_free;
            if (req_valid && slot_free) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            call_start = 1'b1;
            if (!call_busy) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            call_stall = 1'b0;
            if (call_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         ready_en <= 1'b0;
         call_id  <= 32'd0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         if (accept) begin
            call_id <= req_id;
         end
      end
   end

   // Result FIFO. Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage is not reset. The outputs are gated with rsp_valid, so stale
   // entries are never visible.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {call_id, call_returndata};
      end
   end

   assign rsp_valid = (fifo_count != '0);
   assign rsp_id    = rsp_valid ? mem[rd_ptr][95:64] : 32'd0;
   assign rsp_name  = rsp_valid ? mem[rd_ptr][63:0]  : 64'd0;

`ifdef V4L2_NAME_NULL_FILTER_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         drop_count <= 16'd0;
      end else if (done_in_wait && null_result && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end
`else
   assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_v4l2_ctrl_name_dispatch.sv
module tb_v4l2_ctrl_name_dispatch;

   logic        clock;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_id;
   logic        call_start;
   logic        call_busy;
   logic [31:0] call_id;
   logic        call_done;
   logic [63:0] call_returndata;
   logic        call_stall;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_id;
   logic [63:0] rsp_name;
   logic [15:0] drop_count;

   int checks;
   int errors;

`ifdef V4L2_NAME_NULL_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   v4l2_ctrl_name_dispatch #(.FIFO_DEPTH(4)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_id          (req_id),
      .call_start      (call_start),
      .call_busy       (call_busy),
      .call_id         (call_id),
      .call_done       (call_done),
      .call_returndata (call_returndata),
      .call_stall      (call_stall),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_name        (rsp_name),
      .drop_count      (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drives one request at the current negedge and plays the get_name side:
   // busy for busy_n cycles, then done with rd after lat cycles. The task
   // returns #1 after the negedge of the cycle following done.
   task automatic do_call(input logic [31:0] id, input logic [63:0] rd,
                          input int lat, input int busy_n, input bit chk_empty);
      req_valid = 1'b1;
      req_id    = id;
      #1 chk("req_ready_idle", req_ready, 1);
      @(negedge clock);
      req_valid = 1'b0;
      req_id    = 32'h5A5A_5A5A;
      call_busy = (busy_n != 0);
      #1;
      chk("start_t1", call_start, 1);
      chk("call_id_t1", call_id, id);
      chk("stall_issue", call_stall, 1);
      chk("req_ready_busy", req_ready, 0);
      for (int i = 0; i < busy_n; i++) begin
         @(negedge clock);
         if (i == busy_n - 1) call_busy = 1'b0;
         #1;
         chk("busy_hold_start", call_start, 1);
         chk("busy_hold_id", call_id, id);
      end
      for (int i = 0; i < lat; i++) begin
         @(negedge clock);
         #1;
         chk("wait_start_low", call_start, 0);
         chk("wait_stall_low", call_stall, 0);
         if (i == lat - 1) begin
            if (chk_empty) chk("no_bypass", rsp_valid, 0);
            call_done       = 1'b1;
            call_returndata = rd;
         end
      end
      @(negedge clock);
      call_done       = 1'b0;
      call_returndata = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
   endtask

   typedef struct {
      logic [31:0] id;
      logic [63:0] rd;
      int          lat;
      int          busy;
   } vec_t;

   vec_t tbl[4];

   initial begin
      checks          = 0;
      errors          = 0;
      resetn          = 1'b0;
      req_valid       = 1'b1;
      req_id          = 32'h0000_0001;
      call_busy       = 1'b0;
      call_done       = 1'b0;
      call_returndata = 64'd0;
      rsp_ready       = 1'b0;

      tbl[0] = '{32'h0098_0900, 64'h0000_0000_1000_0040, 3, 0};
      tbl[1] = '{32'h0098_0901, 64'hFFFF_8000_1234_5678, 1, 4};
      tbl[2] = '{32'h0098_0999, 64'h0000_0000_0000_0000, 2, 0};
      tbl[3] = '{32'h009A_0001, 64'hDEAD_BEEF_CAFE_F00D, 5, 1};

      // Reset behaviour
      repeat (3) @(negedge clock);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_call_start", call_start, 0);
      chk("rst_call_stall", call_stall, 1);
      chk("rst_call_id", call_id, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_name", rsp_name, 0);
      chk("rst_drop", drop_count, 0);
      @(negedge clock);
      resetn    = 1'b1;
      req_valid = 1'b0;
      @(negedge clock);
      #1 chk("post_rst_ready", req_ready, 1);

      // Table-driven single transactions, popped after each
      for (int v = 0; v < 4; v++) begin
         @(negedge clock);
         do_call(tbl[v].id, tbl[v].rd, tbl[v].lat, tbl[v].busy, 1'b1);
         if (FILTER && tbl[v].rd == 64'd0) begin
            chk("null_dropped", rsp_valid, 0);
         end else begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, tbl[v].id);
            chk("rsp_name", rsp_name, tbl[v].rd);
            @(negedge clock);
            #1 chk("rsp_hold_id", rsp_id, tbl[v].id);
            rsp_ready = 1'b1;
            @(negedge clock);
            rsp_ready = 1'b0;
            #1 chk("pop_empty", rsp_valid, 0);
         end
      end
      chk("drop_count", drop_count, FILTER ? 64'd1 : 64'd0);

      // FIFO full: four results queued, fifth request blocked
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         do_call(32'h00A0_0000 + k, 64'h0000_0000_0000_0100 + k, 1, 0, 1'b0);
      end
      @(negedge clock);
      req_valid = 1'b1;
      req_id    = 32'h00A0_0004;
      #1;
      chk("full_blocked", req_ready, 0);
      chk("full_head", rsp_id, 32'h00A0_0000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         #1 chk("full_blocked_hold", req_ready, 0);
      end
      @(negedge clock);
      rsp_ready = 1'b1;
      #1 chk("full_pop_cycle", req_ready, 0);
      @(negedge clock);
      rsp_ready = 1'b0;
      #1 chk("full_head_after_pop", rsp_id, 32'h00A0_0001);
      do_call(32'h00A0_0004, 64'h0000_0000_0000_0104, 2, 0, 1'b0);
      for (int k = 1; k < 5; k++) begin
         chk("drain_valid", rsp_valid, 1);
         chk("drain_id", rsp_id, 32'h00A0_0000 + k);
         chk("drain_name", rsp_name, 64'h0000_0000_0000_0100 + k);
         rsp_ready = 1'b1;
         @(negedge clock);
         #1;
      end
      rsp_ready = 1'b0;
      chk("drain_empty", rsp_valid, 0);

      // Reset while in WAIT with two queued entries
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         do_call(32'h00B0_0000 + k, 64'h0000_0000_0000_0200 + k, 1, 0, 1'b0);
      end
      @(negedge clock);
      req_valid = 1'b1;
      req_id    = 32'h00B0_0002;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      #1 chk("in_wait_stall", call_stall, 0);
      resetn = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_start", call_start, 0);
      chk("mid_rst_stall", call_stall, 1);
      chk("mid_rst_call_id", call_id, 0);
      chk("mid_rst_drop", drop_count, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      call_done       = 1'b1;
      call_returndata = 64'h0000_0000_0000_0777;
      @(negedge clock);
      call_done = 1'b0;
      #1;
      chk("late_done_ignored", rsp_valid, 0);
      chk("post_rst_ready2", req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
